iram_bit_ctrl: RTL and testbench

Parametrised internal data memory controller for the 8051 core: lower RAM (00h–7Fh), optional upper indirect RAM (80h–FFh), and the SFR byte array, with 8051-standard bit addressing. It replaces the single-cycle blocking-assignment RAM with a req/ack state machine. The state machine performs true read-modify-write for bit operations, range-checks indirect accesses, and runs a self-clearing init sweep after reset. It sits between the core's execute stage and the on-chip data storage.

---
 rtl/iram_bit_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_iram_bit_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_bit_ctrl.sv
// ============================================================================
// iram_bit_ctrl
// ----------------------------------------------------------------------------
// Internal data memory controller for an 8051-class core. It owns three
// 128-byte storage arrays and serves one request at a time through a
// req/ack handshake:
//   - lower RAM  (LRAM, 00h-7Fh): reachable both directly and indirectly
//   - SFR bytes  (80h-FFh, direct addressing only)
//   - upper RAM  (IRAM, 80h-FFh, indirect addressing only), present only
//     when IDATA_DEPTH = 256
// Bit accesses use the standard 8051 bit map and are done as a true
// read-modify-write, so other bits of the target byte are preserved.
// After reset a 128-cycle sweep clears every byte and loads SP (81h).
//
// Parameters
//   IDATA_DEPTH  128 (no upper RAM) or 256
//   SP_RESET     value written into SFR 81h by the init sweep
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   req_i      access request, sampled on a rising edge while busy_o = 0
//   mode_i     00 byte direct, 01 byte indirect, 10 bit, 11 reserved (error)
//   wr_i       1 = write, 0 = read
//   addr_i     byte address (modes 00/01) or bit address (mode 10)
//   wdata_i    write byte
//   wbit_i     write bit value
//   busy_o     high whenever a new request cannot be accepted
//   ack_o      one-cycle completion pulse
//   rdata_o    read byte (byte read, or updated byte after a bit write);
//              held until the next ack that updates it
//   rbit_o     read bit (bit accesses, the old bit value for bit writes)
//   err_o      pulses with ack_o when the access was illegal (no effect)
// ============================================================================
module iram_bit_ctrl #(
    parameter int          IDATA_DEPTH = 256,
    parameter logic [7:0]  SP_RESET    = 8'h07
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [1:0] mode_i,
    input  logic       wr_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       wbit_i,
    output logic       busy_o,
    output logic       ack_o,
    output logic [7:0] rdata_o,
    output logic       rbit_o,
    output logic       err_o
);

    localparam bit HAS_UPPER = (IDATA_DEPTH == 256);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_BYTE   = 3'd2,
        S_BFETCH = 3'd3,
        S_BWRITE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_LRAM = 2'd0,
        SEL_SFR  = 2'd1,
        SEL_IRAM = 2'd2
    } sel_t;

    // ------------------------------------------------------------------
    // State and captured request fields
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        wr_q,    wr_d;
    sel_t        sel_q,   sel_d;
    logic [6:0]  idx_q,   idx_d;
    logic [2:0]  bit_q,   bit_d;
    logic        wbit_q,  wbit_d;
    logic        err_q,   err_d;
    logic [7:0]  word_q,  word_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rbit_q,  rbit_d;

    // ------------------------------------------------------------------
    // Address decode of the incoming request
    // ------------------------------------------------------------------
    logic        dec_legal;
    sel_t        dec_sel;
    logic [6:0]  dec_idx;
    logic [2:0]  dec_bit;

    always_comb begin
        dec_legal = 1'b1;
        dec_sel   = SEL_LRAM;
        dec_idx   = addr_i[6:0];
        dec_bit   = addr_i[2:0];
        case (mode_i)
            2'b00: begin
                if (addr_i[7]) begin
                    dec_sel = SEL_SFR;
                end
            end
            2'b01: begin
                if (addr_i[7]) begin
                    if (HAS_UPPER) begin
                        dec_sel = SEL_IRAM;
                    end else begin
                        dec_legal = 1'b0;
                    end
                end
            end
            2'b10: begin
                if (addr_i[7]) begin
                    // Bit-addressable SFRs sit on 8-byte boundaries.
                    dec_sel = SEL_SFR;
                    dec_idx = {addr_i[6:3], 3'b000};
                end else begin
                    // Bits 00h-7Fh live in LRAM bytes 20h-2Fh.
                    dec_idx = {3'b010, addr_i[6:3]};
                end
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory write port control
    // ------------------------------------------------------------------
    logic        init_wr;
    logic        op_we;
    sel_t        op_sel;
    logic [6:0]  mem_widx;
    logic [7:0]  mem_wdata;
    logic [7:0]  sfr_wdata;
    logic [7:0]  word_new;
    logic        lram_we;
    logic        sfr_we;

    // Target byte with only the addressed bit replaced.
    always_comb begin
        word_new         = word_q;
        word_new[bit_q]  = wbit_q;
    end

    assign init_wr = (state_q == S_INIT);

    always_comb begin
        op_we     = 1'b0;
        op_sel    = dec_sel;
        mem_widx  = dec_idx;
        mem_wdata = wdata_i;
        case (state_q)
            S_INIT: begin
                mem_widx  = cnt_q[6:0];
                mem_wdata = 8'h00;
            end
            S_IDLE: begin
                // Byte writes commit on the same edge that accepts them.
                op_we = req_i & dec_legal & wr_i & ~mode_i[1];
            end
            S_BWRITE: begin
                op_we     = 1'b1;
                op_sel    = sel_q;
                mem_widx  = idx_q;
                mem_wdata = word_new;
            end
            default: begin
            end
        endcase
    end

    assign lram_we   = init_wr | (op_we & (op_sel == SEL_LRAM));
    assign sfr_we    = init_wr | (op_we & (op_sel == SEL_SFR));
    // SFR index 01h is the stack pointer (81h).
    assign sfr_wdata = (init_wr && (cnt_q[6:0] == 7'h01)) ? SP_RESET : mem_wdata;

    // ------------------------------------------------------------------
    // Storage arrays. Reads are registered and addressed by the incoming
    // request, so the data is ready in the cycle right after acceptance,
    // which is exactly when BYTE/BFETCH consume it.
    // ------------------------------------------------------------------
    logic [7:0] lram_mem [0:127];
    logic [7:0] sfr_mem  [0:127];
    logic [7:0] lram_rd_q;
    logic [7:0] sfr_rd_q;
    logic [7:0] iram_rd_q;

    always_ff @(posedge clk_i) begin
        if (lram_we) begin
            lram_mem[mem_widx] <= mem_wdata;
        end
        lram_rd_q <= lram_mem[dec_idx];
    end

    always_ff @(posedge clk_i) begin
        if (sfr_we) begin
            sfr_mem[mem_widx] <= sfr_wdata;
        end
        sfr_rd_q <= sfr_mem[dec_idx];
    end

    generate
        if (HAS_UPPER) begin : g_upper
            logic [7:0] iram_mem [0:127];
            logic       iram_we;

            assign iram_we = init_wr | (op_we & (op_sel == SEL_IRAM));

            always_ff @(posedge clk_i) begin
                if (iram_we) begin
                    iram_mem[mem_widx] <= mem_wdata;
                end
                iram_rd_q <= iram_mem[dec_idx];
            end
        end else begin : g_no_upper
            assign iram_rd_q = 8'h00;
        end
    endgenerate

    // Byte selected by the request captured at acceptance.
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = 8'h00;
        case (sel_q)
            SEL_LRAM: rd_byte = lram_rd_q;
            SEL_SFR:  rd_byte = sfr_rd_q;
            SEL_IRAM: rd_byte = iram_rd_q;
            default:  rd_byte = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= 8'h00;
            wr_q    <= 1'b0;
            sel_q   <= SEL_LRAM;
            idx_q   <= 7'h00;
            bit_q   <= 3'h0;
            wbit_q  <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= 8'h00;
            rdata_q <= 8'h00;
            rbit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            wbit_q  <= wbit_d;
            err_q   <= err_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            rbit_q  <= rbit_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        wbit_d  = wbit_q;
        err_d   = err_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        rbit_d  = rbit_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd127) begin
                    cnt_d   = 8'h00;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_i) begin
                    wr_d   = wr_i;
                    sel_d  = dec_sel;
                    idx_d  = dec_idx;
                    bit_d  = dec_bit;
                    wbit_d = wbit_i;
                    err_d  = ~dec_legal;
                    if (!dec_legal) begin
                        state_d = S_DONE;
                    end else if (mode_i[1]) begin
                        state_d = S_BFETCH;
                    end else if (wr_i) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                rdata_d = rd_byte;
                state_d = S_DONE;
            end
            S_BFETCH: begin
                word_d  = rd_byte;
                rbit_d  = rd_byte[bit_q];
                state_d = wr_q ? S_BWRITE : S_DONE;
            end
            S_BWRITE: begin
                rdata_d = word_new;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o  = (state_q != S_IDLE);
    assign ack_o   = (state_q == S_DONE);
    assign err_o   = (state_q == S_DONE) & err_q;
    assign rdata_o = rdata_q;
    assign rbit_o  = rbit_q;

endmodule

// File: tb/tb_iram_bit_ctrl.sv
module tb_iram_bit_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [1:0] mode;
    logic       wr;
    logic [7:0] addr, wdata;
    logic       wbit;

    logic       busy_a, ack_a, rbit_a, err_a;
    logic [7:0] rdata_a;
    logic       busy_b, ack_b, rbit_b, err_b;
    logic [7:0] rdata_b;

    always #5 clk = ~clk;

    iram_bit_ctrl #(.IDATA_DEPTH(256), .SP_RESET(8'h07)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .mode_i(mode), .wr_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wbit_i(wbit),
        .busy_o(busy_a), .ack_o(ack_a), .rdata_o(rdata_a), .rbit_o(rbit_a), .err_o(err_a)
    );

    iram_bit_ctrl #(.IDATA_DEPTH(128), .SP_RESET(8'h07)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .mode_i(mode), .wr_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wbit_i(wbit),
        .busy_o(busy_b), .ack_o(ack_b), .rdata_o(rdata_b), .rbit_o(rbit_b), .err_o(err_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        bit         chk_rdata;
        logic       rbit;
        bit         chk_rbit;
        logic       err;
        int         lat;
        int         issue;
        string      name;
    } exp_t;

    typedef struct {
        int         dut;
        logic [1:0] mode;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       wbit;
        exp_t       e;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[$];
    exp_t ea, eb;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic mon(string tag, exp_t e, logic [7:0] rd, logic rb, logic er);
        int lat;
        lat = cyc - e.issue + 1;
        $display("txn %s %s: err=%0b rdata=%02h rbit=%0b lat=%0d", tag, e.name, er, rd, rb, lat);
        chk({e.name, "_err"}, {31'd0, er}, {31'd0, e.err});
        if (e.chk_rdata) chk({e.name, "_rdata"}, {24'd0, rd}, {24'd0, e.rdata});
        if (e.chk_rbit)  chk({e.name, "_rbit"}, {31'd0, rb}, {31'd0, e.rbit});
        chk({e.name, "_lat"}, lat, e.lat);
    endtask

    // Scoreboard monitors: every ack pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && ack_a === 1'b1) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_ack_a: got ack=1 expected no ack");
            end else begin
                ea = q_a.pop_front();
                mon("a", ea, rdata_a, rbit_a, err_a);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ack_b === 1'b1) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_ack_b: got ack=1 expected no ack");
            end else begin
                eb = q_b.pop_front();
                mon("b", eb, rdata_b, rbit_b, err_b);
            end
        end
    end

    task automatic add_vec(int d, logic [1:0] m, logic w, logic [7:0] a, logic [7:0] wd, logic wb,
                           logic [7:0] e_rd, bit c_rd, logic e_rb, bit c_rb, logic e_err,
                           int lat, string nm);
        vec_t v;
        v.dut = d; v.mode = m; v.wr = w; v.addr = a; v.wdata = wd; v.wbit = wb;
        v.e.rdata = e_rd; v.e.chk_rdata = c_rd; v.e.rbit = e_rb; v.e.chk_rbit = c_rb;
        v.e.err = e_err; v.e.lat = lat; v.e.issue = 0; v.e.name = nm;
        vecs.push_back(v);
    endtask

    task automatic wait_drain(int d);
        int n;
        n = 0;
        while (((d == 0) ? q_a.size() : q_b.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (((d == 0) ? q_a.size() : q_b.size()) != 0) begin
            total++; bad++;
            $display("FAIL ack_timeout_%0d: got no ack within 20 cycles expected ack", d);
            if (d == 0) q_a.delete(); else q_b.delete();
        end
    endtask

    task automatic do_txn(vec_t v);
        exp_t e;
        @(negedge clk);
        mode = v.mode; wr = v.wr; addr = v.addr; wdata = v.wdata; wbit = v.wbit;
        e = v.e;
        e.issue = cyc + 1;
        if (v.dut == 0) begin req_a = 1'b1; q_a.push_back(e); end
        else            begin req_b = 1'b1; q_b.push_back(e); end
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        wait_drain(v.dut);
    endtask

    task automatic txn(int d, logic [1:0] m, logic w, logic [7:0] a, logic [7:0] wd, logic wb,
                       logic [7:0] e_rd, bit c_rd, logic e_rb, bit c_rb, logic e_err,
                       int lat, string nm);
        vec_t v;
        v.dut = d; v.mode = m; v.wr = w; v.addr = a; v.wdata = wd; v.wbit = wb;
        v.e.rdata = e_rd; v.e.chk_rdata = c_rd; v.e.rbit = e_rb; v.e.chk_rbit = c_rb;
        v.e.err = e_err; v.e.lat = lat; v.e.issue = 0; v.e.name = nm;
        do_txn(v);
    endtask

    // Reset both DUTs, hold a read of SP (81h) on dut_a through the sweep,
    // and count busy cycles until busy first falls.
    task automatic reset_and_sweep(string tag);
        exp_t e;
        int ca, cb;
        bit lowa, lowb;
        rst = 1'b1;
        mode = 2'b00; wr = 1'b0; addr = 8'h81; wdata = 8'h00; wbit = 1'b0;
        req_a = 1'b1; req_b = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_rst_busy_a"}, {31'd0, busy_a}, 32'd1);
        chk({tag, "_rst_ack_a"}, {31'd0, ack_a}, 32'd0);
        chk({tag, "_rst_err_a"}, {31'd0, err_a}, 32'd0);
        chk({tag, "_rst_rdata_a"}, {24'd0, rdata_a}, 32'd0);
        chk({tag, "_rst_rbit_a"}, {31'd0, rbit_a}, 32'd0);
        chk({tag, "_rst_busy_b"}, {31'd0, busy_b}, 32'd1);
        chk({tag, "_rst_rdata_b"}, {24'd0, rdata_b}, 32'd0);
        rst = 1'b0;
        e.rdata = 8'h07; e.chk_rdata = 1'b1; e.rbit = 1'b0; e.chk_rbit = 1'b0;
        e.err = 1'b0; e.lat = 2; e.issue = cyc + 129; e.name = {tag, "_held_rd_sp"};
        q_a.push_back(e);
        ca = 0; cb = 0; lowa = 1'b0; lowb = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_a) lowa = 1'b1; else if (!lowa) ca++;
            if (!busy_b) lowb = 1'b1; else if (!lowb) cb++;
            if (i == 129) req_a = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles_a"}, ca, 128);
        chk({tag, "_busy_cycles_b"}, cb, 128);
        wait_drain(0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        mode = 2'b00; wr = 1'b0; addr = 8'h00; wdata = 8'h00; wbit = 1'b0;

        //       dut mode  wr addr   wdata wb  e_rd  crd e_rb crb err lat name
        add_vec(0, 2'b00, 0, 8'h81, 8'h00, 0, 8'h07, 1, 0, 0, 0, 2, "rd_d81");
        add_vec(0, 2'b00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "rd_d00");
        add_vec(0, 2'b00, 0, 8'h7F, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "rd_d7f");
        add_vec(0, 2'b00, 0, 8'h90, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "rd_d90");
        add_vec(0, 2'b00, 1, 8'h30, 8'hA5, 0, 8'h00, 1, 0, 0, 0, 1, "wr_d30");
        add_vec(0, 2'b00, 0, 8'h30, 8'h00, 0, 8'hA5, 1, 0, 0, 0, 2, "rd_d30");
        add_vec(0, 2'b01, 0, 8'h30, 8'h00, 0, 8'hA5, 1, 0, 0, 0, 2, "rd_i30");
        add_vec(0, 2'b01, 1, 8'h90, 8'h3C, 0, 8'hA5, 1, 0, 0, 0, 1, "wr_i90");
        add_vec(0, 2'b00, 0, 8'h90, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "rd_d90_sfr");
        add_vec(0, 2'b01, 0, 8'h90, 8'h00, 0, 8'h3C, 1, 0, 0, 0, 2, "rd_i90");
        add_vec(0, 2'b00, 1, 8'h21, 8'h00, 0, 8'h3C, 1, 0, 0, 0, 1, "wr_d21");
        add_vec(0, 2'b10, 1, 8'h0B, 8'h00, 1, 8'h08, 1, 0, 1, 0, 3, "bw_0b");
        add_vec(0, 2'b00, 0, 8'h21, 8'h00, 0, 8'h08, 1, 0, 0, 0, 2, "rd_d21");
        add_vec(0, 2'b10, 0, 8'h0B, 8'h00, 0, 8'h00, 0, 1, 1, 0, 2, "br_0b");
        add_vec(0, 2'b10, 0, 8'h0C, 8'h00, 0, 8'h00, 0, 0, 1, 0, 2, "br_0c");
        add_vec(0, 2'b10, 1, 8'hE7, 8'h00, 1, 8'h80, 1, 0, 1, 0, 3, "bw_e7");
        add_vec(0, 2'b00, 0, 8'hE0, 8'h00, 0, 8'h80, 1, 0, 0, 0, 2, "rd_de0");
        add_vec(0, 2'b11, 0, 8'h00, 8'h00, 0, 8'h80, 1, 0, 0, 1, 1, "mode3_rd");
        add_vec(0, 2'b11, 1, 8'h55, 8'hFF, 0, 8'h80, 1, 0, 0, 1, 1, "mode3_wr");
        add_vec(0, 2'b10, 0, 8'hE7, 8'h00, 0, 8'h00, 0, 1, 1, 0, 2, "br_e7");
        add_vec(0, 2'b10, 0, 8'h7F, 8'h00, 0, 8'h00, 0, 0, 1, 0, 2, "br_7f");
        add_vec(1, 2'b01, 1, 8'h90, 8'h55, 0, 8'h00, 1, 0, 0, 1, 1, "b_wr_i90");
        add_vec(1, 2'b00, 0, 8'h90, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "b_rd_d90");
        add_vec(1, 2'b00, 1, 8'h10, 8'h77, 0, 8'h00, 1, 0, 0, 0, 1, "b_wr_d10");
        add_vec(1, 2'b01, 0, 8'h10, 8'h00, 0, 8'h77, 1, 0, 0, 0, 2, "b_rd_i10");
        add_vec(1, 2'b01, 0, 8'hFF, 8'h00, 0, 8'h77, 1, 0, 0, 1, 1, "b_rd_iff");

        reset_and_sweep("init");

        foreach (vecs[i]) do_txn(vecs[i]);

        // Reset while a bit write of bit 00h=1 sits in BWRITE.
        @(negedge clk);
        mode = 2'b10; wr = 1'b1; addr = 8'h00; wbit = 1'b1; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_rdata", {24'd0, rdata_a}, 32'd0);
        chk("async_rst_rbit", {31'd0, rbit_a}, 32'd0);
        chk("async_rst_busy", {31'd0, busy_a}, 32'd1);
        reset_and_sweep("midrst");

        txn(0, 2'b00, 0, 8'h20, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "post_rd_d20");
        txn(0, 2'b10, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 2, "post_br_00");
        txn(0, 2'b00, 0, 8'hE0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 2, "post_rd_de0");
        txn(0, 2'b00, 1, 8'h30, 8'h5A, 0, 8'h00, 1, 0, 0, 0, 1, "wr_d30_5a");

        // A write request raised while busy must be dropped.
        begin
            exp_t e;
            @(negedge clk);
            mode = 2'b00; wr = 1'b0; addr = 8'h30; req_a = 1'b1;
            e.rdata = 8'h5A; e.chk_rdata = 1'b1; e.rbit = 1'b0; e.chk_rbit = 1'b0;
            e.err = 1'b0; e.lat = 2; e.issue = cyc + 1; e.name = "rd_d30_busy";
            q_a.push_back(e);
            @(negedge clk);
            chk("busy_in_byte", {31'd0, busy_a}, 32'd1);
            wr = 1'b1; wdata = 8'hFF;
            @(negedge clk);
            req_a = 1'b0; wr = 1'b0;
            wait_drain(0);
        end
        repeat (4) @(negedge clk);
        txn(0, 2'b00, 0, 8'h30, 8'h00, 0, 8'h5A, 1, 0, 0, 0, 2, "rd_d30_after_drop");

        repeat (3) @(negedge clk);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
